// File: rtl/fmul_arbiter.sv
// fmul_arbiter: shares one external single-precision multiplier between two requesters
// using round-robin arbitration, with a 2-entry in-order result FIFO per requester. Optional counters: FMUL_ARBITER_PERF_EN.
module fmul_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x1,
    input  logic [31:0] req0_x2,
    input  logic [3:0]  req0_tag,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x1,
    input  logic [31:0] req1_x2,
    input  logic [3:0]  req1_tag,
    output logic        res0_valid,
    input  logic        res0_ready,
    output logic [31:0] res0_y,
    output logic [3:0]  res0_tag,
    output logic        res1_valid,
    input  logic        res1_ready,
    output logic [31:0] res1_y,
    output logic [3:0]  res1_tag,
    output logic [31:0] mul_x1,
    output logic [31:0] mul_x2,
    input  logic [31:0] mul_y
`ifdef FMUL_ARBITER_PERF_EN
    ,
    output logic [31:0] perf_issue_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    logic [1:0]  req_valid, req_ready, res_valid, res_ready, elig, push, pop;
    logic        gnt, gnt_id, last_gnt;
    logic        inf_valid, inf_id;
    logic [3:0]  inf_tag;
    logic [1:0]  occ_n    [2];
    logic [31:0] head_y   [2];
    logic [3:0]  head_tag [2];

    assign req_valid  = {req1_valid, req0_valid};
    assign res_ready  = {res1_ready, res0_ready};
    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign res0_valid = res_valid[0];
    assign res1_valid = res_valid[1];
    assign res0_y     = rst ? '0 : head_y[0];
    assign res1_y     = rst ? '0 : head_y[1];
    assign res0_tag   = rst ? '0 : head_tag[0];
    assign res1_tag   = rst ? '0 : head_tag[1];

    always_comb begin
        elig      = '0;
        push      = '0;
        pop       = '0;
        res_valid = '0;
        mul_x1    = '0;
        mul_x2    = '0;
        // An in-flight op already owns a FIFO slot; pops this cycle are deliberately ignored.
        for (int unsigned n = 0; n < 2; n++) begin
            push[n]      = inf_valid && (inf_id == 1'(n));
            elig[n]      = req_valid[n] && ((occ_n[n] + 2'(push[n])) < 2'd2);
            res_valid[n] = !rst && (occ_n[n] != 2'd0);
            pop[n]       = res_valid[n] && res_ready[n];
        end
        gnt       = !rst && (elig != 2'b00);
        gnt_id    = (elig == 2'b11) ? ~last_gnt : elig[1];
        req_ready = gnt ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
        if (gnt) begin
            mul_x1 = gnt_id ? req1_x1 : req0_x1;
            mul_x2 = gnt_id ? req1_x2 : req0_x2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inf_valid <= 1'b0;
            inf_id    <= 1'b0;
            inf_tag   <= '0;
            last_gnt  <= 1'b1;
        end else begin
            inf_valid <= gnt;
            if (gnt) begin
                inf_id   <= gnt_id;
                inf_tag  <= gnt_id ? req1_tag : req0_tag;
                last_gnt <= gnt_id;
            end
        end
    end

    for (genvar n = 0; n < 2; n++) begin : g_fifo
        logic [1:0]       occ;
        logic             rd_ptr, wr_ptr;
        logic [1:0][31:0] mem_y;
        logic [1:0][3:0]  mem_tag;

        always_ff @(posedge clk) begin
            if (rst) begin
                occ     <= '0;
                rd_ptr  <= 1'b0;
                wr_ptr  <= 1'b0;
                mem_y   <= '0;
                mem_tag <= '0;
            end else begin
                if (push[n]) begin
                    mem_y[wr_ptr]   <= mul_y;
                    mem_tag[wr_ptr] <= inf_tag;
                    wr_ptr          <= ~wr_ptr;
                end
                if (pop[n])
                    rd_ptr <= ~rd_ptr;
                occ <= occ + 2'(push[n]) - 2'(pop[n]);
            end
        end

        assign occ_n[n]    = occ;
        assign head_y[n]   = mem_y[rd_ptr];
        assign head_tag[n] = mem_tag[rd_ptr];
    end

`ifdef FMUL_ARBITER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (gnt)
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if ((req_valid & ~req_ready) != 2'b00)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fmul_arbiter.sv
// Scoreboard bench for fmul_arbiter; the bench also plays the external 1-cycle multiplier.
module tb_fmul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
    logic [3:0]  req0_tag, req1_tag;
    logic        res0_valid, res0_ready, res1_valid, res1_ready;
    logic [31:0] res0_y, res1_y;
    logic [3:0]  res0_tag, res1_tag;
    logic [31:0] mul_x1, mul_x2, mul_y;
`ifdef FMUL_ARBITER_PERF_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

    int          vectors = 0;
    int          errors  = 0;
    logic [35:0] q0 [$];
    logic [35:0] q1 [$];
    logic [35:0] exp_r;

    always #5 clk = ~clk;

    fmul_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x1(req0_x1), .req0_x2(req0_x2), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x1(req1_x1), .req1_x2(req1_x2), .req1_tag(req1_tag),
        .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_y(res0_y), .res0_tag(res0_tag),
        .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_y(res1_y), .res1_tag(res1_tag),
        .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_y(mul_y)
`ifdef FMUL_ARBITER_PERF_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Truncating multiply for normal operands; exact for the fixed vectors used below.
    function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], 8'(e), m};
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
    endfunction

    always @(posedge clk) mul_y <= fmul_model(mul_x1, mul_x2);

    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready) q0.push_back({fmul_model(req0_x1, req0_x2), req0_tag});
            if (req1_valid && req1_ready) q1.push_back({fmul_model(req1_x1, req1_x2), req1_tag});
            if (res0_valid && res0_ready) begin
                vectors++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL res0_unexpected: got y=%h tag=%h, required no result", res0_y, res0_tag);
                end else begin
                    exp_r = q0.pop_front();
                    if ({res0_y, res0_tag} !== exp_r) begin
                        errors++;
                        $display("FAIL res0_data: got y=%h tag=%h, required y=%h tag=%h",
                                 res0_y, res0_tag, exp_r[35:4], exp_r[3:0]);
                    end
                end
            end
            if (res1_valid && res1_ready) begin
                vectors++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL res1_unexpected: got y=%h tag=%h, required no result", res1_y, res1_tag);
                end else begin
                    exp_r = q1.pop_front();
                    if ({res1_y, res1_tag} !== exp_r) begin
                        errors++;
                        $display("FAIL res1_data: got y=%h tag=%h, required y=%h tag=%h",
                                 res1_y, res1_tag, exp_r[35:4], exp_r[3:0]);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_x1 = '0; req0_x2 = '0; req0_tag = '0;
        req1_x1 = '0; req1_x2 = '0; req1_tag = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        repeat (2) next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_x1 = 32'h3F800000; req0_x2 = 32'h40000000; req0_tag = 4'd5;
        req1_valid = 1'b1; req1_x1 = 32'h40400000; req1_x2 = 32'h40000000; req1_tag = 4'd6;
        res0_ready = 1'b1; res1_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready, res0_valid, res1_valid, res0_y, res0_tag, res1_y, res1_tag, mul_x1, mul_x2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b%b rv=%b%b y0=%h y1=%h mx=%h/%h, required all zero",
                     req0_ready, req1_ready, res0_valid, res1_valid, res0_y, res1_y, mul_x1, mul_x2);
        end
        next_cycle();
        rst = 1'b0;
        idle();
    endtask

    task automatic test_single();
        res0_ready = 1'b1;
        req0_valid = 1'b1; req0_x1 = 32'h40000000; req0_x2 = 32'h40400000; req0_tag = 4'd3;
        @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready, mul_x1, mul_x2} !== {2'b10, 32'h40000000, 32'h40400000}) begin
            errors++;
            $display("FAIL single_grant: got rdy=%b%b mx=%h/%h, required rdy=10 mx=40000000/40400000",
                     req0_ready, req1_ready, mul_x1, mul_x2);
        end
        next_cycle();
        idle();
        @(negedge clk);
        vectors++;
        if (res0_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle1: got res0_valid=%b, required 0", res0_valid);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({res0_valid, res0_y, res0_tag} !== {1'b1, 32'h40C00000, 4'd3}) begin
            errors++;
            $display("FAIL single_cycle2: got v=%b y=%h tag=%h, required v=1 y=40c00000 tag=3",
                     res0_valid, res0_y, res0_tag);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (res0_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle3: got res0_valid=%b, required 0", res0_valid);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic        exp0;
        logic [31:0] exp_x1;
        do_reset();
        res0_ready = 1'b1; res1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1; req0_x1 = rnd_f(); req0_x2 = rnd_f(); req0_tag = 4'($urandom);
            req1_valid = 1'b1; req1_x1 = rnd_f(); req1_x2 = rnd_f(); req1_tag = 4'($urandom);
            exp0   = (i % 2) == 0;
            exp_x1 = exp0 ? req0_x1 : req1_x1;
            @(negedge clk);
            vectors++;
            if ({req0_ready, req1_ready, mul_x1} !== {exp0, ~exp0, exp_x1}) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got rdy=%b%b mx1=%h, required rdy=%b%b mx1=%h",
                         i, req0_ready, req1_ready, mul_x1, exp0, ~exp0, exp_x1);
            end
            next_cycle();
        end
        idle();
        repeat (4) next_cycle();
    endtask

    task automatic test_backpressure();
        int   nt;
        logic exp_rdy [9] = '{1, 1, 0, 0, 0, 0, 1, 0, 0};
        logic exp_rv  [9] = '{0, 0, 1, 1, 1, 1, 1, 0, 1};
        int   exp_tg  [9] = '{0, 0, 1, 1, 1, 1, 2, 0, 3};
        nt = 1;
        for (int c = 0; c < 9; c++) begin
            res0_ready = (c >= 5);
            req0_valid = (nt <= 3);
            req0_x1 = 32'h3FC00000; req0_x2 = 32'h3FC00000; req0_tag = 4'(nt);
            @(negedge clk);
            vectors++;
            if (req0_ready !== exp_rdy[c] || res0_valid !== exp_rv[c] ||
                (exp_rv[c] && {res0_y, res0_tag} !== {32'h40100000, 4'(exp_tg[c])})) begin
                errors++;
                $display("FAIL backpressure[%0d]: got rdy=%b rv=%b y=%h tag=%h, required rdy=%b rv=%b y=40100000 tag=%0d",
                         c, req0_ready, res0_valid, res0_y, res0_tag, exp_rdy[c], exp_rv[c], exp_tg[c]);
            end
            if (req0_valid && req0_ready) nt++;
            next_cycle();
        end
        idle();
        res0_ready = 1'b1;
        repeat (3) next_cycle();
    endtask

    task automatic test_full_push_pop();
        res0_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c == 4) res0_ready = 1'b1;
            req0_valid = 1'b1;
            if (c == 0 || req0_ready) begin
                req0_x1 = rnd_f(); req0_x2 = rnd_f(); req0_tag = 4'($urandom);
            end
            @(negedge clk);
            if (c == 4) begin
                vectors++;
                if ({req0_ready, res0_valid} !== 2'b01) begin
                    errors++;
                    $display("FAIL full_pop_noreuse: got rdy=%b rv=%b, required rdy=0 rv=1", req0_ready, res0_valid);
                end
            end
            if (c == 5) begin
                vectors++;
                if ({req0_ready, res0_valid} !== 2'b11) begin
                    errors++;
                    $display("FAIL full_after_pop: got rdy=%b rv=%b, required rdy=1 rv=1", req0_ready, res0_valid);
                end
            end
            next_cycle();
        end
        idle();
        repeat (4) next_cycle();
    endtask

    task automatic test_reset_mid();
        res0_ready = 1'b0; res1_ready = 1'b1;
        req0_valid = 1'b1; req0_x1 = 32'h40000000; req0_x2 = 32'h40000000; req0_tag = 4'd9;
        next_cycle();
        req0_tag = 4'd10;
        next_cycle();
        idle();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready, res0_valid, res1_valid, res0_y, res0_tag, mul_x1, mul_x2} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got rv0=%b y0=%h tag0=%h, required all zero", res0_valid, res0_y, res0_tag);
        end
        next_cycle();
        rst = 1'b0;
        res0_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({res0_valid, res1_valid} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_discard[%0d]: got rv=%b%b, required 00", c, res0_valid, res1_valid);
            end
            next_cycle();
        end
        req0_valid = 1'b1; req0_x1 = rnd_f(); req0_x2 = rnd_f(); req0_tag = 4'd1;
        req1_valid = 1'b1; req1_x1 = rnd_f(); req1_x2 = rnd_f(); req1_tag = 4'd2;
        @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_tie: got rdy=%b%b, required 10", req0_ready, req1_ready);
        end
        next_cycle();
        idle();
    endtask

`ifdef FMUL_ARBITER_PERF_EN
    task automatic test_perf();
        do_reset();
        res0_ready = 1'b1; res1_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            req0_valid = 1'b1; req0_x1 = rnd_f(); req0_x2 = rnd_f(); req0_tag = 4'(c);
            req1_valid = 1'b1; req1_x1 = rnd_f(); req1_x2 = rnd_f(); req1_tag = 4'(c);
            next_cycle();
        end
        idle();
        @(negedge clk);
        vectors++;
        if ({perf_issue_cnt, perf_stall_cnt} !== {32'd10, 32'd10}) begin
            errors++;
            $display("FAIL perf_counters: got issue=%0d stall=%0d, required issue=10 stall=10",
                     perf_issue_cnt, perf_stall_cnt);
        end
        next_cycle();
    endtask
`endif

    task automatic test_drain();
        idle();
        res0_ready = 1'b1; res1_ready = 1'b1;
        repeat (6) next_cycle();
        @(negedge clk);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0 || {res0_valid, res1_valid} !== 2'b00) begin
            errors++;
            $display("FAIL drain: got pending=%0d/%0d rv=%b%b, required 0/0 rv=00",
                     q0.size(), q1.size(), res0_valid, res1_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        res0_ready = 1'b0; res1_ready = 1'b0;
        idle();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid();
`ifdef FMUL_ARBITER_PERF_EN
        test_perf();
`endif
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, listed first: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 The block SHALL expose two request ports, n=0,1: reqn_valid  input  1  operation offered; reqn_ready  output  1  operation accepted this cycle; reqn_x1  input  32  operand 1 (IEEE single); reqn_x2  input  32  operand 2; reqn_tag  input  4  requester tag.
REQ-003 The block SHALL expose two result ports, n=0,1: resn_valid  output  1  result available; resn_ready  input  1  result consumed; resn_y  output  32  product; resn_tag  output  4  tag of the product.
REQ-004 The block SHALL expose the shared multiplier port: mul_x1  output  32  operand 1 to the multiplier; mul_x2  output  32  operand 2; mul_y  input  32  product, valid exactly one cycle after its operands are presented.

Function
REQ-005 Requester n SHALL be eligible when reqn_valid=1 and (FIFO n occupancy + 1 if an in-flight op targets n) < 2; same-cycle pops SHALL NOT count toward eligibility.
REQ-006 At most one grant per cycle; reqn_ready=1 only for the granted requester; accept occurs when reqn_valid and reqn_ready are both 1.
REQ-007 Arbitration SHALL be round-robin: if both are eligible, grant the requester not granted most recently; if only one is eligible, grant it; the last-grant pointer SHALL update only on a grant.
REQ-008 In a grant cycle, mul_x1/mul_x2 SHALL carry the granted requester's operands combinationally; otherwise both SHALL be 32'h0.
REQ-009 On grant, in-flight state {valid, id, tag} SHALL be registered; in the following cycle mul_y SHALL be written with that tag into FIFO id (issue to result-visible latency 2 cycles).
REQ-010 Back-to-back grants SHALL sustain throughput of one op per cycle across requesters.
REQ-011 Each result FIFO SHALL be 2 entries, in order; resn_valid=1 iff non-empty; resn_y/resn_tag SHALL show the head entry.
REQ-012 A pop occurs when resn_valid and resn_ready are both 1; push and pop in the same cycle SHALL leave occupancy unchanged, including at occupancy 2.
REQ-013 Overflow is impossible by construction (REQ-005); popping an empty FIFO SHALL be ignored.
REQ-014 Results to one requester SHALL be returned in acceptance order; no ordering is guaranteed between requesters.

Reset
REQ-015 While rst=1: all reqn_ready=0, resn_valid=0, resn_y=0, resn_tag=0, mul_x1=mul_x2=0.
REQ-016 Reset SHALL empty both FIFOs, clear in-flight valid and set the last-grant pointer to 1, so that requester 0 wins the first tie.
REQ-017 Reset mid-operation SHALL discard any in-flight product; mul_y in the cycle after reset deasserts SHALL be ignored.

Configuration
REQ-018 Macro FMUL_ARBITER_PERF_EN SHALL gate performance counters.
REQ-019 With FMUL_ARBITER_PERF_EN defined, the block SHALL add outputs perf_issue_cnt (32) and perf_stall_cnt (32); issue counts grants; stall counts cycles where some reqn_valid=1 with no grant to that requester; both SHALL reset to 0 and wrap modulo 2^32.
REQ-020 Without FMUL_ARBITER_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-021 req0 x1=0x40000000, x2=0x40400000, tag=3, res0_ready=1 -> req0_ready in cycle 0; res0_valid in cycle 2 with y=0x40C00000, tag=3.
REQ-022 Both requesters valid every cycle, all res_ready=1, after reset -> grants alternate 0,1,0,1, first grant to requester 0, one grant per cycle.
REQ-023 req0 issues 3 ops (1.5*1.5, x=0x3FC00000) with res0_ready=0 -> 2 accepted, req0_ready=0 afterwards; FIFO holds two 0x40100000 entries; raising res0_ready drains in order and the third op is accepted.
REQ-024 FIFO0 full with res0_ready=1 and a new push in the same cycle -> occupancy stays 2, no data lost, order preserved.
REQ-025 rst asserted for one cycle while an op is in flight -> no resn_valid afterwards; the next tie is granted to requester 0.
REQ-026 With FMUL_ARBITER_PERF_EN: 10 cycles, both requesters always valid, no backpressure -> perf_issue_cnt=10, perf_stall_cnt=10.
